axis_beat_player: RTL
=====================

AXIS_BEAT_PLAYER -- requirements
Module: axis_beat_player

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: AXI-Stream data width in bits, a multiple of 8.
REQ-002 SHALL have parameter MTY_WIDTH, default 6: empty-byte field width, equal to log2(DATA_WIDTH/8).
REQ-003 SHALL have parameter DEPTH, default 64: number of beat-memory entries, a power of 2; AW = log2(DEPTH).
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of the gap and packet counters.
REQ-005 SHALL have one clock and asynchronous active-low reset: clk  in  1  rising-edge clock; aresetn  in  1  async active-low reset.
REQ-006 SHALL have ports wr_en  in  1  beat-memory write strobe; wr_addr  in  AW  entry index.
REQ-007 SHALL have ports wr_tdata  in  DATA_WIDTH  beat data; wr_mty  in  MTY_WIDTH  empty bytes; wr_last  in  1  end-of-packet flag; wr_crc  in  32  packet CRC.
REQ-008 SHALL have ports start  in  1  run request; num_beats  in  AW+1  entries to play; gap_cycles  in  CNT_WIDTH  idle cycles between packets.
REQ-009 SHALL have ports busy  out  1  run in progress; done  out  1  one-cycle end-of-run pulse; pkt_count  out  CNT_WIDTH  packets sent; wr_err  out  1  write-rejected pulse.
REQ-010 SHALL have ports m_axis_tdata  out  DATA_WIDTH; m_axis_tuser_mty  out  MTY_WIDTH; m_axis_tcrc  out  32; m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1.

Function
REQ-011 SHALL hold DEPTH entries of {tdata, mty, last, crc}; the memory SHALL have no reset and SHALL be read combinationally.
REQ-012 SHALL write entry wr_addr on a clk edge when wr_en=1 and the FSM is in IDLE.
REQ-013 SHALL drop wr_en while busy=1, with no memory change, and pulse wr_err for one cycle.
REQ-014 SHALL implement FSM states IDLE, PLAY, GAP; busy=1 in PLAY and GAP.
REQ-015 SHALL, on start=1 in IDLE: latch N = min(num_beats, DEPTH), latch gap_cycles, clear pkt_count and the beat index.
REQ-016 SHALL, on start with N=0: stay in IDLE, pulse done the next cycle, assert no tvalid.
REQ-017 SHALL, on start with N>0: enter PLAY and assert m_axis_tvalid with entry 0 on the next cycle (1-cycle latency).
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL hold all m_axis outputs stable while tvalid=1 and tready=0.
REQ-020 SHALL, on a handshake of a non-last beat, present the next entry on the following cycle with tvalid still 1 (back-to-back, full throughput).
REQ-021 SHALL drive m_axis_tlast = entry.last, forced to 1 on beat N-1.
REQ-022 SHALL drive m_axis_tuser_mty = entry.mty when tlast=1, else 0.
REQ-023 SHALL drive m_axis_tcrc = entry.crc when tlast=1, else 0.
REQ-024 SHALL increment pkt_count on every handshake with tlast=1, saturating at all-ones.
REQ-025 SHALL, after a tlast handshake with beats remaining and gap>0: enter GAP, hold tvalid=0 for exactly gap cycles, then return to PLAY.
REQ-026 SHALL, after a tlast handshake with beats remaining and gap=0: present the next entry the following cycle.
REQ-027 SHALL, after the handshake of beat N-1: deassert tvalid, pulse done for one cycle, return to IDLE.

Reset
REQ-028 SHALL, on aresetn=0 at any time including mid-packet: immediately enter IDLE and clear tvalid, tlast, busy, done, wr_err, pkt_count, the index and the gap counter; memory contents SHALL be retained.
REQ-029 SHALL drive m_axis_tdata, m_axis_tuser_mty and m_axis_tcrc to 0 in reset.

Verification
REQ-030 Load a 1-beat packet (mty=0, last=1, crc=0), N=1, tready=1 -> tvalid exactly 1 cycle, beginning the cycle after start; tlast=1; done 1 cycle later; pkt_count=1.
REQ-031 Load 3 packets of 2 beats, gap=30, tready=1 -> 2-beat bursts separated by exactly 30 idle cycles; pkt_count=3; tcrc and mty nonzero only on last beats.
REQ-032 Toggle tready every other cycle during a run -> no beat lost or duplicated; outputs stable while stalled.
REQ-033 Entry 3 with last=0, N=4 -> beat 3 emitted with tlast=1.
REQ-034 start with N=0 -> done next cycle, no tvalid; wr_en while busy -> wr_err pulse and memory unchanged on readback replay.
REQ-035 Assert aresetn=0 mid-packet -> tvalid=0 and busy=0 immediately; a subsequent start replays the retained memory from entry 0.

Source files
------------

// File: rtl/axis_beat_player.sv
`default_nettype none
// ============================================================================
//  Module      : axis_beat_player
//  Description : Replays a preloaded table of AXI-Stream beats (data, empty
//                bytes, last flag, CRC) with a programmable idle gap between
//                packets. Reports packet count and end of run.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_beat_player #(
  parameter int DATA_WIDTH = 512,
  parameter int MTY_WIDTH  = 6,
  parameter int DEPTH      = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  // Beat-memory write port
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_tdata,
  input  logic [MTY_WIDTH-1:0]     wr_mty,
  input  logic                     wr_last,
  input  logic [31:0]              wr_crc,
  // Run control and status
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   num_beats,
  input  logic [CNT_WIDTH-1:0]     gap_cycles,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_WIDTH-1:0]     pkt_count,
  output logic                     wr_err,
  // AXI-Stream master
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [MTY_WIDTH-1:0]     m_axis_tuser_mty,
  output logic [31:0]              m_axis_tcrc,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast
);

  localparam int             c_aw       = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_depth    = (c_aw+1)'(DEPTH);
  localparam logic [c_aw:0]  c_n_one    = (c_aw+1)'(1);
  localparam logic [c_aw-1:0] c_idx_one = c_aw'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Beat memory: no reset so contents survive aresetn
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [MTY_WIDTH-1:0]  r_mem_mty  [DEPTH];
  logic                  r_mem_last [DEPTH];
  logic [31:0]           r_mem_crc  [DEPTH];

  logic [c_aw-1:0]      r_idx;
  logic [c_aw:0]        r_n;
  logic [CNT_WIDTH-1:0] r_gap_lat;
  logic [CNT_WIDTH-1:0] r_gap_cnt;
  logic [CNT_WIDTH-1:0] r_pkt_count;
  logic                 r_done;
  logic                 r_wr_err;

  logic [c_aw:0] w_n_clamp;
  logic          w_valid;
  logic          w_final;
  logic          w_tlast;
  logic          w_hs;

  assign w_n_clamp = (num_beats > c_depth) ? c_depth : num_beats;
  assign w_valid   = (r_state == PLAY);
  assign w_final   = (({1'b0, r_idx} + c_n_one) == r_n);
  assign w_tlast   = w_valid && (r_mem_last[r_idx] || w_final);
  assign w_hs      = w_valid && m_axis_tready;

  // Outputs are gated to zero whenever no beat is being offered
  assign m_axis_tvalid    = w_valid;
  assign m_axis_tlast     = w_tlast;
  assign m_axis_tdata     = w_valid ? r_mem_data[r_idx] : '0;
  assign m_axis_tuser_mty = w_tlast ? r_mem_mty[r_idx]  : '0;
  assign m_axis_tcrc      = w_tlast ? r_mem_crc[r_idx]  : '0;
  assign busy             = (r_state != IDLE);
  assign done             = r_done;
  assign wr_err           = r_wr_err;
  assign pkt_count        = r_pkt_count;

  // Memory write, accepted only while idle
  always_ff @(posedge clk) begin
    if (wr_en && (r_state == IDLE)) begin
      r_mem_data[wr_addr] <= wr_tdata;
      r_mem_mty[wr_addr]  <= wr_mty;
      r_mem_last[wr_addr] <= wr_last;
      r_mem_crc[wr_addr]  <= wr_crc;
    end
  end

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start && (w_n_clamp != '0)) w_next = PLAY;
      end
      PLAY: begin
        if (w_hs) begin
          if (w_final)                             w_next = IDLE;
          else if (w_tlast && (r_gap_lat != '0))   w_next = GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt <= c_cnt_one) w_next = PLAY;
      end
      default: w_next = IDLE;
    endcase
  end

  // Run bookkeeping: beat index, latched run parameters, counters and pulses
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_idx       <= '0;
      r_n         <= '0;
      r_gap_lat   <= '0;
      r_gap_cnt   <= '0;
      r_pkt_count <= '0;
      r_done      <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_wr_err <= wr_en && (r_state != IDLE);
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_n         <= w_n_clamp;
            r_gap_lat   <= gap_cycles;
            r_pkt_count <= '0;
            r_idx       <= '0;
            if (w_n_clamp == '0) r_done <= 1'b1;
          end
        end
        PLAY: begin
          if (w_hs) begin
            if (w_tlast && (r_pkt_count != '1)) r_pkt_count <= r_pkt_count + c_cnt_one;
            if (w_final) begin
              r_done <= 1'b1;
            end else begin
              r_idx <= r_idx + c_idx_one;
              if (w_tlast) r_gap_cnt <= r_gap_lat;
            end
          end
        end
        GAP: begin
          r_gap_cnt <= r_gap_cnt - c_cnt_one;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
